// File: rtl/intlv_pkg.sv
// Shared definitions for the convolutional byte interleaver front end.
// Provides branch geometry, the branch index type, the bypass stage payload
// and the branch-to-RAM-strobe decoder.
package intlv_pkg;

   localparam int unsigned NBR        = 12;       // branches, fixed by RAM partitioning
   localparam int unsigned BRANCH_LEN = 17;       // RAM cells per branch unit delay
   localparam int unsigned NRAM       = NBR - 1;  // branches backed by the shift RAM
   localparam int unsigned BR_W       = 4;
   localparam int unsigned DATA_W     = 8;

   typedef logic [BR_W-1:0] branch_t;

   // Stage S1 payload: byte in flight between accept and output FIFO write
   typedef struct packed {
      logic              valid;
      logic              src;   // 1: byte comes back from the shift RAM
      logic [DATA_W-1:0] byp;
   } s1_t;

   // One-hot RAM write strobe for branch eb; branch 0 has no RAM slot
   function automatic logic [NRAM-1:0] branch_onehot(input branch_t eb);
      return (eb == '0) ? '0 : (NRAM'(1) << (eb - branch_t'(1)));
   endfunction

endpackage

// File: rtl/intlv_out_fifo.sv
// Synchronous byte FIFO with occupancy count; shared with the de-interleaver.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   wr_en, wr_data write request (ignored when full)
//   rd_en          pop request (ignored when empty)
//   head_c         head entry (combinational view of storage)
//   count          registered occupancy
module intlv_out_fifo
   import intlv_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] head_c,
   output logic [CNT_W-1:0]  count
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              wr_ok_c, rd_ok_c;

   // Pointers wrap explicitly so non power-of-two depths work
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Next-state: guarded write/pop, pointer and count update
   always_comb begin
      wr_ok_c  = wr_en && (count_q != CNT_W'(DEPTH));
      rd_ok_c  = rd_en && (count_q != '0);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_ok_c) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (rd_ok_c) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CNT_W'(wr_ok_c) - CNT_W'(rd_ok_c);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head_c = mem_q[rd_ptr_q];
   assign count  = count_q;

endmodule

// File: rtl/intlv_branch_ctrl.sv
// Front-end controller of the convolutional byte interleaver.
// Commutates accepted bytes round-robin over NBR branches: branch 0 is a
// registered bypass, branches 1..11 are written/read through fifo_shift_ram.
// Bypass and RAM bytes are merged in order into a small output FIFO.
// Optional feature macro: INTLV_SYNC_CHECK_EN (sync misalignment pulse/count).
// Ports:
//   clk, reset_n                       clock, asynchronous active-low reset
//   in_valid/in_ready/in_data/in_sync  input byte handshake, sync forces branch 0
//   push/sel/ram_re/ram_din            shift RAM strobes (combinational on accept)
//   ram_dout                           RAM read data, one cycle after ram_re
//   out_valid/out_ready/out_data       output stream from the FIFO head
//   sync_err/err_cnt                   misalignment pulse and saturating count
module intlv_branch_ctrl
   import intlv_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_sync,
   output logic [NRAM-1:0]   push,
   output logic [BR_W-1:0]   sel,
   output logic              ram_re,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              sync_err,
   output logic [7:0]        err_cnt
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned SUM_W = CNT_W + 1;

   branch_t           bc_q, bc_d;
   branch_t           sel_q, sel_d;
   s1_t               s1_q, s1_d;
   branch_t           eb_c;
   logic              acc_c, strobe_c;
   logic [CNT_W-1:0]  fifo_cnt;
   logic [DATA_W-1:0] fifo_wdata_c;

   // Accept, branch selection and RAM strobes; in_ready looks only at
   // registered occupancy, and is held low in reset so no strobe escapes
   always_comb begin
      in_ready = reset_n &&
                 ((SUM_W'(fifo_cnt) + SUM_W'(s1_q.valid)) < SUM_W'(FIFO_DEPTH - 1));
      acc_c    = in_valid && in_ready;
      eb_c     = in_sync ? '0 : bc_q;
      strobe_c = acc_c && (eb_c != '0);

      bc_d = bc_q;
      if (acc_c) begin
         bc_d = (eb_c == branch_t'(NBR - 1)) ? '0 : eb_c + branch_t'(1);
      end

      push    = strobe_c ? branch_onehot(eb_c) : '0;
      ram_re  = strobe_c;
      ram_din = strobe_c ? in_data : '0;
      sel_d   = strobe_c ? eb_c - branch_t'(1) : sel_q;
      sel     = sel_d;

      s1_d = '0;
      if (acc_c) begin
         s1_d.valid = 1'b1;
         s1_d.src   = (eb_c != '0);
         s1_d.byp   = in_data;
      end

      fifo_wdata_c = s1_q.src ? ram_dout : s1_q.byp;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bc_q  <= '0;
         sel_q <= '0;
         s1_q  <= '0;
      end else begin
         bc_q  <= bc_d;
         sel_q <= sel_d;
         s1_q  <= s1_d;
      end
   end

   intlv_out_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_out_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (s1_q.valid),
      .wr_data (fifo_wdata_c),
      .rd_en   (out_valid && out_ready),
      .head_c  (out_data),
      .count   (fifo_cnt)
   );

   assign out_valid = (fifo_cnt != '0);

`ifdef INTLV_SYNC_CHECK_EN
   logic       sync_err_q, sync_err_d;
   logic [7:0] err_cnt_q, err_cnt_d;

   // A sync byte arriving off branch 0 means the stream lost alignment
   always_comb begin
      sync_err_d = acc_c && in_sync && (bc_q != '0);
      err_cnt_d  = err_cnt_q;
      if (sync_err_d && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_err_q <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         sync_err_q <= sync_err_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign sync_err = sync_err_q;
   assign err_cnt  = err_cnt_q;
`else
   assign sync_err = 1'b0;
   assign err_cnt  = '0;
`endif

endmodule

// File: doc/intlv_branch_ctrl.md
Name: intlv_branch_ctrl

Overview:
- Front-end controller of the convolutional byte interleaver, directly upstream of fifo_shift_ram.
- Accepts a byte stream over a valid/ready handshake and commutates bytes round-robin over 12 branches.
- Branch 0 is a one-cycle registered bypass; branches 1..11 drive the shift RAM (push one-hot, sel, din, ram_re).
- Merges bypass and RAM read data back into one in-order output stream through a small output FIFO with downstream back-pressure.

Parameters:
- FIFO_DEPTH, 4, output FIFO entries; legal values 4..16.
- NBR, 12, branch count; fixed by RAM partitioning, not to be overridden.

Ports:
- clk  in  1  single clock; also drives fifo_shift_ram.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input byte valid.
- in_ready  out  1  input accepted when in_valid && in_ready.
- in_data  in  8  input byte.
- in_sync  in  1  accepted byte is a packet sync byte; forces branch 0.
- push  out  11  one-hot RAM write strobe; push[b-1] selects branch b.
- sel  out  4  branch select to RAM, value b-1 (0..10).
- ram_re  out  1  RAM read enable.
- ram_din  out  8  write data to RAM.
- ram_dout  in  8  RAM read data, valid 1 cycle after ram_re.
- out_valid  out  1  output FIFO not empty.
- out_ready  in  1  downstream accepts head.
- out_data  out  8  output FIFO head.
- sync_err  out  1  misalignment pulse (optional feature).
- err_cnt  out  8  saturating misalignment count (optional feature).

Behaviour:
- Reset: branch counter bc=0, s1_valid=0, FIFO count=0. All outputs 0: out_valid, push, sel, ram_re, ram_din, sync_err, err_cnt. in_ready is 1 after reset.
- Reset is asynchronous. Assertion mid-stream discards in-flight and queued bytes. No RAM strobe may be issued while reset_n=0.
- Accept condition: acc = in_valid && in_ready.
- in_ready = (count + s1_valid) < FIFO_DEPTH-1, computed from registers only; no combinational path from out_ready.
- Branch selection on acc:
  - Effective branch eb = in_sync ? 0 : bc.
  - Next bc = (eb==11) ? 0 : eb+1. bc holds when there is no acc.
- RAM strobes for acc with eb in 1..11, all combinational in the accept cycle:
  - push = 1<<(eb-1), sel = eb-1, ram_din = in_data, ram_re = 1.
  - With eb=0 or no acc: push=0, ram_re=0, sel holds its last value.
- Stage S1, registered on acc: s1_valid=1, s1_src=(eb!=0), s1_byp=in_data. Otherwise s1_valid=0.
- The cycle after acc: FIFO writes (s1_src ? ram_dout : s1_byp). Latency from acc to out_valid is 2 cycles when the FIFO is empty.
- FIFO pops on out_valid && out_ready. Simultaneous push and pop leaves count unchanged. The in_ready rule guarantees the FIFO never overflows.
- Sustained throughput is 1 byte/cycle with out_ready=1.
- The RAM holds undefined content until filled. Delay of branch b is b*17*12 bytes. Output is meaningful only after 2244 accepted bytes.

Optional Feature:
- Macro: INTLV_SYNC_CHECK_EN.
- Defined: on acc with in_sync=1 and bc!=0, sync_err pulses for 1 cycle (registered) and err_cnt increments, saturating at 255. The realignment to branch 0 still occurs.
- Undefined: sync_err and err_cnt tied to 0. Realignment on in_sync is unchanged.

Decomposition:
- Shared package intlv_pkg:
  - NBR=12, BRANCH_LEN=17.
  - Branch index typedef (4 bits).
  - Function branch_onehot(eb) returning 11 bits.
- One sub-module: intlv_out_fifo, a synchronous FIFO of FIFO_DEPTH x 8 with count output; reusable by the de-interleaver.

Test Plan:
- Reset, then 12 bytes 0x00..0x0B with no sync and out_ready=1 -> push walks 0x000, 0x001, 0x002 .. 0x400; sel 0..10 on bytes 1..11; ram_re=0 on byte 0; bc back to 0.
- Send 5 bytes, then in_sync=1 on the 6th -> 6th byte has push=0 and bypass data 2 cycles later; 7th byte has push=0x001; with INTLV_SYNC_CHECK_EN, sync_err=1 and err_cnt=1.
- Hold out_ready=0 while streaming -> in_ready drops once count+s1_valid=3, no overflow; release -> order preserved, no byte lost.
- Zero-fill the RAM via 2244 bytes of 0x00, then stream 0x01.. -> branch b output byte equals the input accepted b*204 bytes earlier on the same branch.
- Assert reset_n mid-stream with count=3 -> out_valid and push drop immediately; after release the first accepted byte maps to branch 0.
- 300 sync bytes each at bc!=0 -> err_cnt saturates at 255.
